serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial ripple-borrow subtractor. An operand set (S, A, Bin) is captured
// on a valid/ready handshake, then one bit per clock is processed LSB first.
// After INPUT_SIZE bit-steps the result is presented with out_valid and held
// until the consumer takes it with out_ready.
//
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN
//   When defined, adds output ovf (two's-complement signed overflow of S - A).
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand set presented
//   in_ready   out  high only while IDLE
//   S          in   [INPUT_SIZE] minuend
//   A          in   [INPUT_SIZE] subtrahend
//   Bin        in   borrow into bit 0
//   out_valid  out  high only while DONE
//   out_ready  in   consumer takes the result
//   D          out  [INPUT_SIZE] difference S - A - Bin mod 2^INPUT_SIZE
//   Bout       out  borrow out of the MSB
//   borrow_vec out  [INPUT_SIZE] borrow leaving each bit position
//   ovf        out  signed overflow (only with SERIAL_SUB_OVERFLOW_EN)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int INPUT_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INPUT_SIZE-1:0] S,
  input  logic [INPUT_SIZE-1:0] A,
  input  logic                  Bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INPUT_SIZE-1:0] D,
  output logic                  Bout,
  output logic [INPUT_SIZE-1:0] borrow_vec
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic                  ovf
`endif
);

  localparam int CW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);
  localparam int MSB = INPUT_SIZE - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [INPUT_SIZE-1:0] r_s;
  logic [INPUT_SIZE-1:0] r_a;
  // Running borrow: holds Bin for bit 0, then the borrow from the previous bit.
  logic                  r_b;
  logic                  r_in_ready;
  logic                  r_out_valid;

  logic w_s, w_a, w_d, w_bo, w_last;

  // Single full-subtractor cell, fed from the captured operands so that
  // input changes during BUSY cannot disturb the result.
  always_comb begin
    w_s    = r_s[r_cnt];
    w_a    = r_a[r_cnt];
    w_d    = w_s ^ w_a ^ r_b;
    w_bo   = (~w_s & w_a) | (~(w_s ^ w_a) & r_b);
    w_last = (r_cnt == LAST);
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_s         <= '0;
      r_a         <= '0;
      r_b         <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      D           <= '0;
      Bout        <= 1'b0;
      borrow_vec  <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf         <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          // in_ready is known high here, so in_valid alone completes the handshake.
          if (in_valid) begin
            r_s        <= S;
            r_a        <= A;
            r_b        <= Bin;
            r_cnt      <= '0;
            r_state    <= BUSY;
            r_in_ready <= 1'b0;
          end
        end

        BUSY: begin
          D[r_cnt]          <= w_d;
          borrow_vec[r_cnt] <= w_bo;
          r_b               <= w_bo;
          if (w_last) begin
            Bout        <= w_bo;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // Operand signs differ and the result sign departs from the minuend.
            ovf         <= (r_s[MSB] != r_a[MSB]) && (w_d != r_s[MSB]);
`endif
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        DONE: begin
          // in_ready stays low on this edge: no acceptance on the DONE->IDLE edge.
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
